// File: rtl/exc_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | exc_ctrl_pkg : shared ExcCodes, CP0 addresses, FSM encoding, exc_req bits  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package exc_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FLUSH    = 2'd1,
      S_REDIRECT = 2'd2
   } exc_state_e;

   localparam logic [4:0] c_exc_int  = 5'd0;
   localparam logic [4:0] c_exc_adel = 5'd4;
   localparam logic [4:0] c_exc_sys  = 5'd8;
   localparam logic [4:0] c_exc_bp   = 5'd9;
   localparam logic [4:0] c_exc_ov   = 5'd12;

   // CP0 addresses are {rd[4:0], sel[2:0]}
   localparam logic [7:0] c_cp0_badvaddr = 8'h40;
   localparam logic [7:0] c_cp0_count    = 8'h48;
   localparam logic [7:0] c_cp0_compare  = 8'h58;
   localparam logic [7:0] c_cp0_status   = 8'h60;
   localparam logic [7:0] c_cp0_cause    = 8'h68;
   localparam logic [7:0] c_cp0_epc      = 8'h70;

   localparam int c_req_adel = 4;
   localparam int c_req_ov   = 3;
   localparam int c_req_sys  = 2;
   localparam int c_req_brk  = 1;
   localparam int c_req_eret = 0;

   // Only meaningful when the winner is not eret.
   function automatic logic [4:0] exc_code_sel(input logic int_pend, input logic [4:0] req);
      if (int_pend)             return c_exc_int;
      else if (req[c_req_adel]) return c_exc_adel;
      else if (req[c_req_ov])   return c_exc_ov;
      else if (req[c_req_sys])  return c_exc_sys;
      else                      return c_exc_bp;
   endfunction

endpackage

`default_nettype wire

// File: rtl/exc_ctrl_cp0_timer.sv
// +----------------------------------------------------------------------------+
// | cp0_timer : CP0 Count/Compare and timer interrupt flag TI                  |
// | Built only when EXC_CTRL_TIMER_EN is defined.  Rev 1.0                     |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifdef EXC_CTRL_TIMER_EN
module cp0_timer (
   input  logic        clk,
   input  logic        resetn,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic [31:0] count_q, count_d, compare_q, compare_d;
   logic        ti_q, ti_d;

   always_comb begin
      count_d   = count_we ? wdata : count_q + 32'd1;
      compare_d = compare_we ? wdata : compare_q;
      ti_d      = compare_we ? 1'b0 : (ti_q | (count_q == compare_q));
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         count_q   <= 32'd0;
         compare_q <= 32'd0;
         ti_q      <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign count   = count_q;
   assign compare = compare_q;
   assign ti      = ti_q;

endmodule
`endif

`default_nettype wire

// File: rtl/exc_ctrl.sv
// +----------------------------------------------------------------------------+
// | exc_ctrl : exception/interrupt controller, CP0 regs, flush/redirect FSM    |
// | Optional Count/Compare timer with EXC_CTRL_TIMER_EN.  Rev 1.0              |
// +----------------------------------------------------------------------------+
`default_nettype none

module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_ENTRY = 32'h0000_0000,
   parameter int          INT_LINES = 6
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 WB_valid,
   input  logic [31:0]          WB_pc,
   input  logic [4:0]           exc_req,
   input  logic [31:0]          bad_vaddr,
   input  logic [INT_LINES-1:0] hw_int,
   input  logic                 mtc0,
   input  logic [7:0]           cp0_waddr,
   input  logic [31:0]          cp0_wdata,
   output logic [31:0]          cp0_rdata,
   output logic                 wb_kill,
   output logic                 cancel,
   output logic [32:0]          exc_bus,
   input  logic                 exc_ready,
   output logic                 exc_busy
);

   exc_state_e  state_q, state_d;
   logic [7:0]  im_q, im_d;
   logic        exl_q, exl_d, ie_q, ie_d;
   logic [1:0]  ip_sw_q, ip_sw_d;
   logic [5:0]  ip_hw_q;
   logic [4:0]  code_q, code_d;
   logic [31:0] epc_q, epc_d, badva_q, badva_d, target_q, target_d;

   logic [7:0]  w_ip;
   logic        w_ti, w_int_pend, w_take, w_is_eret, w_cp0_we;
   logic [31:0] w_count, w_compare;

   assign w_ip       = {ip_hw_q[5] | w_ti, ip_hw_q[4:0], ip_sw_q};
   assign w_int_pend = ie_q & ~exl_q & (|(w_ip & im_q));
   assign w_take     = (state_q == S_IDLE) & WB_valid & (w_int_pend | (|exc_req));
   assign w_is_eret  = ~w_int_pend & (exc_req[4:1] == 4'd0) & exc_req[c_req_eret];
   // syscall/brk/eret never write the regfile, so only these winners need a kill
   assign wb_kill    = w_take & (w_int_pend | exc_req[c_req_adel] | exc_req[c_req_ov]);
   assign w_cp0_we   = (state_q == S_IDLE) & WB_valid & mtc0 & ~w_take;

`ifdef EXC_CTRL_TIMER_EN
   cp0_timer u_timer (
      .clk        (clk),
      .resetn     (resetn),
      .count_we   (w_cp0_we && (cp0_waddr == c_cp0_count)),
      .compare_we (w_cp0_we && (cp0_waddr == c_cp0_compare)),
      .wdata      (cp0_wdata),
      .count      (w_count),
      .compare    (w_compare),
      .ti         (w_ti)
   );
`else
   assign w_ti      = 1'b0;
   assign w_count   = 32'd0;
   assign w_compare = 32'd0;
`endif

   always_comb begin
      state_d  = state_q;
      im_d     = im_q;
      exl_d    = exl_q;
      ie_d     = ie_q;
      ip_sw_d  = ip_sw_q;
      code_d   = code_q;
      epc_d    = epc_q;
      badva_d  = badva_q;
      target_d = target_q;

      case (state_q)
         S_IDLE:     if (w_take) state_d = S_FLUSH;
         S_FLUSH:    state_d = exc_ready ? S_IDLE : S_REDIRECT;
         S_REDIRECT: if (exc_ready) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase

      if (w_take) begin
         if (w_is_eret) begin
            exl_d    = 1'b0;
            target_d = epc_q;
         end else begin
            epc_d    = WB_pc;
            code_d   = exc_code_sel(w_int_pend, exc_req);
            exl_d    = 1'b1;
            target_d = EXC_ENTRY;
            if (!w_int_pend && exc_req[c_req_adel]) badva_d = bad_vaddr;
         end
      end else if (w_cp0_we) begin
         case (cp0_waddr)
            c_cp0_status: begin
               im_d  = cp0_wdata[15:8];
               exl_d = cp0_wdata[1];
               ie_d  = cp0_wdata[0];
            end
            c_cp0_cause: ip_sw_d = cp0_wdata[9:8];
            c_cp0_epc:   epc_d   = cp0_wdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         im_q     <= 8'd0;
         exl_q    <= 1'b0;
         ie_q     <= 1'b0;
         ip_sw_q  <= 2'd0;
         ip_hw_q  <= 6'd0;
         code_q   <= 5'd0;
         target_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         im_q     <= im_d;
         exl_q    <= exl_d;
         ie_q     <= ie_d;
         ip_sw_q  <= ip_sw_d;
         ip_hw_q  <= 6'(hw_int);
         code_q   <= code_d;
         target_q <= target_d;
      end
   end

   // EPC and BadVAddr carry no reset
   always_ff @(posedge clk) begin
      epc_q   <= epc_d;
      badva_q <= badva_d;
   end

   always_comb begin
      cp0_rdata = 32'd0;
      case (cp0_waddr)
         c_cp0_status:   cp0_rdata = {16'd0, im_q, 6'd0, exl_q, ie_q};
         c_cp0_cause:    cp0_rdata = {1'b0, w_ti, 14'd0, w_ip, 1'b0, code_q, 2'd0};
         c_cp0_epc:      cp0_rdata = epc_q;
         c_cp0_badvaddr: cp0_rdata = badva_q;
         c_cp0_count:    cp0_rdata = w_count;
         c_cp0_compare:  cp0_rdata = w_compare;
         default:        cp0_rdata = 32'd0;
      endcase
   end

   assign cancel   = (state_q == S_FLUSH);
   assign exc_busy = (state_q != S_IDLE);
   assign exc_bus  = (state_q != S_IDLE) ? {1'b1, target_q} : 33'd0;

endmodule

`default_nettype wire
